// File: rtl/ps2_pkg.sv
// Shared encodings, packet field positions and the coordinate clamp used
// by the PS/2 mouse receiver.
package ps2_pkg;

    typedef enum logic [1:0] {BS_IDLE, BS_DATA, BS_PARITY, BS_STOP} byte_st_e;
    typedef enum logic [1:0] {PK_B0, PK_B1, PK_B2} pkt_st_e;

    localparam int BTN_L      = 0;
    localparam int BTN_R      = 1;
    localparam int SYNC       = 3;
    localparam int XS         = 4;
    localparam int YS         = 5;
    localparam int XO         = 6;
    localparam int YO         = 7;
    localparam int FRAME_BITS = 8;

    // Fields of byte 0 that survive until byte 2 arrives.
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic right;
        logic left;
    } hdr_t;

    function automatic logic [11:0] clamp(input logic signed [13:0] v,
                                          input logic [11:0]        vmax);
        logic [11:0] r;
        if (v < 14'sd0)
            r = 12'd0;
        else if (v > $signed({2'b00, vmax}))
            r = vmax;
        else
            r = v[11:0];
        return r;
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_byte.sv
// PS/2 device-to-host byte receiver: pad synchronizers, falling-edge sampling,
// 11-bit frame check (start, 8 data, odd parity, stop) and inter-edge timeout.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = 130000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       byte_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_dly_q;
    byte_st_e      st_q, st_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d, err_q, err_d;
    logic          fall, din;

    assign fall = clk_dly_q & ~clk_sync_q[1];
    assign din  = data_sync_q[1];

    // Idle PS/2 lines are high, so synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_dly_q   <= 1'b1;
            st_q        <= BS_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_dly_q   <= clk_sync_q[1];
            st_q        <= st_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_ok_d  = par_ok_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (st_q == BS_IDLE || fall) ? '0 : tmo_q + 1'b1;
        if (fall) begin
            unique case (st_q)
                BS_IDLE: if (!din) begin
                    st_d      = BS_DATA;
                    bit_cnt_d = '0;
                end
                BS_DATA: begin
                    sr_d[bit_cnt_q] = din;
                    bit_cnt_d       = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(FRAME_BITS - 1))
                        st_d = BS_PARITY;
                end
                BS_PARITY: begin
                    par_ok_d = ^{sr_q, din};
                    st_d     = BS_STOP;
                end
                BS_STOP: begin
                    st_d = BS_IDLE;
                    if (din && par_ok_q)
                        done_d = 1'b1;
                    else
                        err_d = 1'b1;
                end
                default: st_d = BS_IDLE;
            endcase
        end else if (st_q != BS_IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
            st_d  = BS_IDLE;
            err_d = 1'b1;
        end
    end

    assign byte_o      = sr_q;
    assign byte_done_o = done_q;
    assign byte_err_o  = err_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse stream receiver: assembles 3-byte movement packets and keeps
// clamped absolute screen coordinates plus button state.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int XMAX    = 1023,
    parameter int YMAX    = 767,
    parameter int X_INIT  = 512,
    parameter int Y_INIT  = 384,
    parameter int TIMEOUT = 130000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        mouse_left,
    output logic        mouse_right,
    output logic        packet_valid,
    output logic        rx_error
);

    localparam logic [11:0] XMAX_V = 12'(XMAX);
    localparam logic [11:0] YMAX_V = 12'(YMAX);

    logic [7:0] rx_byte;
    logic       byte_done, byte_err;

    ps2_rx_byte #(.TIMEOUT(TIMEOUT)) u_byte (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .byte_o     (rx_byte),
        .byte_done_o(byte_done),
        .byte_err_o (byte_err)
    );

    pkt_st_e     pk_q, pk_d;
    hdr_t        hdr_q, hdr_d;
    logic [7:0]  dx_q, dx_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        l_q, l_d, r_q, r_d, pv_q, pv_d, er_q, er_d;

    logic signed [13:0] dx_s, dy_s, x_new, y_new;

    // PS/2 +Y points up while screen Y grows downward, hence the subtraction.
    assign dx_s  = {{6{hdr_q.xs}}, dx_q};
    assign dy_s  = {{6{hdr_q.ys}}, rx_byte};
    assign x_new = $signed({2'b00, x_q}) + dx_s;
    assign y_new = $signed({2'b00, y_q}) - dy_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pk_q  <= PK_B0;
            hdr_q <= '0;
            dx_q  <= '0;
            x_q   <= 12'(X_INIT);
            y_q   <= 12'(Y_INIT);
            l_q   <= 1'b0;
            r_q   <= 1'b0;
            pv_q  <= 1'b0;
            er_q  <= 1'b0;
        end else begin
            pk_q  <= pk_d;
            hdr_q <= hdr_d;
            dx_q  <= dx_d;
            x_q   <= x_d;
            y_q   <= y_d;
            l_q   <= l_d;
            r_q   <= r_d;
            pv_q  <= pv_d;
            er_q  <= er_d;
        end
    end

    always_comb begin
        pk_d  = pk_q;
        hdr_d = hdr_q;
        dx_d  = dx_q;
        x_d   = x_q;
        y_d   = y_q;
        l_d   = l_q;
        r_d   = r_q;
        pv_d  = 1'b0;
        er_d  = 1'b0;
        if (byte_err) begin
            pk_d = PK_B0;
            er_d = 1'b1;
        end else if (byte_done) begin
            unique case (pk_q)
                PK_B0: if (rx_byte[SYNC]) begin
                    hdr_d = '{yo: rx_byte[YO], xo: rx_byte[XO], ys: rx_byte[YS],
                              xs: rx_byte[XS], right: rx_byte[BTN_R], left: rx_byte[BTN_L]};
                    pk_d  = PK_B1;
                end else begin
                    er_d = 1'b1;
                end
                PK_B1: begin
                    dx_d = rx_byte;
                    pk_d = PK_B2;
                end
                PK_B2: begin
                    pk_d = PK_B0;
                    pv_d = 1'b1;
                    l_d  = hdr_q.left;
                    r_d  = hdr_q.right;
                    if (!hdr_q.xo) x_d = clamp(x_new, XMAX_V);
                    if (!hdr_q.yo) y_d = clamp(y_new, YMAX_V);
                end
                default: pk_d = PK_B0;
            endcase
        end
    end

    assign xpos         = x_q;
    assign ypos         = y_q;
    assign mouse_left   = l_q;
    assign mouse_right  = r_q;
    assign packet_valid = pv_q;
    assign rx_error     = er_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: serial PS/2 frames in, per-cycle comparison
// against a packet-level coordinate model, plus literal pins on key results.
module tb_ps2_mouse_rx;

    localparam int TMO = 300;
    localparam int HB  = 4;

    logic        clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [11:0] xpos, ypos;
    logic        mouse_left, mouse_right, packet_valid, rx_error;

    ps2_mouse_rx #(.XMAX(1023), .YMAX(767), .X_INIT(512), .Y_INIT(384), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .xpos        (xpos),
        .ypos        (ypos),
        .mouse_left  (mouse_left),
        .mouse_right (mouse_right),
        .packet_valid(packet_valid),
        .rx_error    (rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int exp_x = 512, exp_y = 384;
    bit exp_l = 0, exp_r = 0;
    // Pending event: kind 1 = packet accepted, kind 2 = error pulse.
    int pend_cyc = -1, pend_kind = 0, pend_x = 0, pend_y = 0;
    bit pend_l = 0, pend_r = 0;
    bit tmo_win = 0;
    int tmo_errs = 0;
    bit epv, eer;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            epv = (pend_cyc == cyc) && (pend_kind == 1);
            eer = (pend_cyc == cyc) && (pend_kind == 2);
            if (epv) begin
                exp_x = pend_x;
                exp_y = pend_y;
                exp_l = pend_l;
                exp_r = pend_r;
            end
            chk("xpos", int'(xpos), exp_x);
            chk("ypos", int'(ypos), exp_y);
            chk("mouse_left", int'(mouse_left), int'(exp_l));
            chk("mouse_right", int'(mouse_right), int'(exp_r));
            chk("packet_valid", int'(packet_valid), int'(epv));
            if (tmo_win) begin
                if (rx_error) tmo_errs++;
            end else begin
                chk("rx_error", int'(rx_error), int'(eer));
            end
        end
    end

    // Raw PS/2 line changes land on the falling clk edge; the stop-bit fall
    // plus two sync stages and two pipeline registers puts the result 4 edges later.
    task automatic send_bit(input bit b, input int kind);
        @(negedge clk);
        ps2_data = b;
        repeat (HB) @(negedge clk);
        ps2_clk = 1'b0;
        if (kind != 0) begin
            pend_cyc  = cyc + 4;
            pend_kind = kind;
        end
        repeat (HB) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind, input bit badpar, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i], (i == 10) ? kind : 0);
        ps2_data = 1'b1;
    endtask

    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy, nx, ny;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        nx = exp_x + dx;
        ny = exp_y - dy;
        nx = (nx < 0) ? 0 : ((nx > 1023) ? 1023 : nx);
        ny = (ny < 0) ? 0 : ((ny > 767) ? 767 : ny);
        pend_x = b0[6] ? exp_x : nx;
        pend_y = b0[7] ? exp_y : ny;
        pend_l = b0[0];
        pend_r = b0[1];
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        model_pkt(b0, b1, b2);
        send_byte(b0, 0, 1'b0, 11);
        send_byte(b1, 0, 1'b0, 11);
        send_byte(b2, 1, 1'b0, 11);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_xpos", int'(xpos), 512);
        chk("rst_ypos", int'(ypos), 384);
        chk("rst_buttons", int'({mouse_left, mouse_right}), 0);
        chk("rst_pulses", int'({packet_valid, rx_error}), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        send_pkt(8'h09, 8'h10, 8'h00);
        chk("lit_click_x", int'(xpos), 528);
        chk("lit_click_left", int'(mouse_left), 1);
        send_pkt(8'h08, 8'h00, 8'h05);
        chk("lit_y_down", int'(ypos), 379);
        send_pkt(8'h0A, 8'h00, 8'h00);
        chk("lit_right", int'(mouse_right), 1);
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h08, 8'hED, 8'h00);
        chk("lit_x_1020", int'(xpos), 1020);
        send_pkt(8'h08, 8'h20, 8'h00);
        chk("lit_x_clamp_hi", int'(xpos), 1023);
        send_pkt(8'h28, 8'h00, 8'h01);
        send_pkt(8'h28, 8'h00, 8'h7D);
        chk("lit_y_765", int'(ypos), 765);
        send_pkt(8'h28, 8'h00, 8'hF6);
        chk("lit_y_clamp_hi", int'(ypos), 767);
        repeat (3) send_pkt(8'h18, 8'h00, 8'h00);
        send_pkt(8'h18, 8'h65, 8'h00);
        chk("lit_x_100", int'(xpos), 100);
        send_pkt(8'h18, 8'h80, 8'h00);
        chk("lit_x_clamp_lo", int'(xpos), 0);
        send_pkt(8'h48, 8'hFF, 8'h00);
        chk("lit_x_ovf_hold", int'(xpos), 0);

        // Bad parity on byte 1, then a clean packet.
        send_byte(8'h08, 0, 1'b0, 11);
        send_byte(8'h01, 2, 1'b1, 11);
        repeat (8) @(negedge clk);
        send_pkt(8'h08, 8'h01, 8'h00);
        chk("lit_after_parity", int'(xpos), 1);

        // Header without the sync bit is dropped.
        send_byte(8'h01, 2, 1'b0, 11);
        repeat (8) @(negedge clk);
        send_pkt(8'h09, 8'h02, 8'h00);
        chk("lit_after_resync", int'(xpos), 3);

        // Partial frame followed by silence.
        send_byte(8'h08, 0, 1'b0, 5);
        tmo_win = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        tmo_win = 1'b0;
        chk("timeout_err_count", tmo_errs, 1);
        send_pkt(8'h08, 8'h05, 8'h00);
        chk("lit_after_timeout", int'(xpos), 8);

        // Asynchronous reset in the middle of byte 1.
        send_byte(8'h08, 0, 1'b0, 11);
        send_byte(8'h01, 0, 1'b0, 5);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_x = 512; exp_y = 384; exp_l = 0; exp_r = 0; pend_cyc = -1;
        #1;
        chk("async_rst_x", int'(xpos), 512);
        chk("async_rst_y", int'(ypos), 384);
        chk("async_rst_btn", int'({mouse_left, mouse_right}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_pkt(8'h28, 8'h03, 8'hFE);
        chk("lit_post_rst_x", int'(xpos), 515);
        chk("lit_post_rst_y", int'(ypos), 386);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
- Produces the `xpos`, `ypos` and `mouse_left` inputs that the menu/game controller consumes.
- Receives PS/2 mouse stream-mode frames, assembles the standard 3-byte movement packet, and accumulates the relative deltas into absolute, clamped screen coordinates for the 1024x768 display domain.
- Receive-only: stream-mode enable is issued by a separate block.

Parameters:
- XMAX, 1023, largest legal xpos
- YMAX, 767, largest legal ypos
- X_INIT, 512, xpos after reset
- Y_INIT, 384, ypos after reset
- TIMEOUT, 130000, clk cycles without a PS/2 falling edge before a partial frame is aborted (2 ms at 65 MHz)

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock from pad, asynchronous
- ps2_data  in  1  raw PS/2 data from pad, asynchronous
- xpos  out  12  absolute X, 0..XMAX
- ypos  out  12  absolute Y, 0..YMAX, grows downward
- mouse_left  out  1  left button state
- mouse_right  out  1  right button state
- packet_valid  out  1  one-cycle pulse on each accepted packet
- rx_error  out  1  one-cycle pulse on parity, framing, sync or timeout error

Behaviour:
- Reset (rst=0, async): xpos=X_INIT, ypos=Y_INIT, buttons=0, packet_valid=0, rx_error=0. All FSMs return to idle and byte index to 0. Reset is honoured mid-frame; the partial frame is discarded.
- Input conditioning: 2-FF synchronizer on both ps2_clk and ps2_data, then a 1-cycle delay for falling-edge detection. A sample is taken on the cycle the synchronized ps2_clk falls.
- Byte FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: a falling edge with data=0 (start bit) goes to DATA; data=1 is ignored.
  - DATA: 8 bits, LSB first, 3-bit counter.
  - PARITY: the sampled bit must make the 9 bits odd parity.
  - STOP: the sampled bit must be 1. Then return to IDLE and emit byte_done plus the byte; error cases emit byte_err instead.
- Timeout: a counter clears on every falling edge and runs in any non-IDLE state. At TIMEOUT it aborts to IDLE and raises byte_err.
- Packet FSM, states B0, B1, B2:
  - B0 accepts a byte only if bit3=1. Otherwise it drops the byte, pulses rx_error and stays in B0 (resync).
  - B1 stores dx[7:0]. B2 stores dy[7:0].
  - Any byte_err returns the packet FSM to B0 without updating outputs.
- Update: on the cycle after byte 2 completes, all outputs update together and packet_valid=1 for exactly one cycle. Latency from the stop-bit falling edge to valid outputs is 2 clk.
- Field decode for byte0:
  - bit0 = left, bit1 = right
  - bit4 = X sign, bit5 = Y sign
  - bit6 = X overflow, bit7 = Y overflow
- Arithmetic:
  - Deltas are 9-bit two's complement {sign, byte}.
  - New X = xpos + sext(dx), computed in 14-bit signed. New Y = ypos - sext(dy), because PS/2 +Y is up and screen +Y is down.
  - Clamp: a result below 0 gives 0; above the max gives XMAX or YMAX.
  - An overflow bit set means that axis is unchanged; the other axis and the buttons still update.
- Error reporting: rx_error pulses once per error event, never in the same cycle as packet_valid.

Decomposition:
- Package ps2_pkg holds:
  - byte FSM and packet FSM state encodings
  - packet bit positions: BTN_L=0, BTN_R=1, SYNC=3, XS=4, YS=5, XO=6, YO=7
  - the frame data-bit count, 8
- Sub-module ps2_rx_byte contains the synchronizer, edge detect, byte FSM, parity check and timeout. Its outputs are byte[7:0], byte_done and byte_err.
- The top level holds the packet FSM, the accumulator and the clamping.

Test Plan:
- Reset and left click: hold rst=0, then release. Expect xpos=512, ypos=384, buttons=0. Send packet 09,10,00. Expect xpos=528, ypos=384, mouse_left=1, one packet_valid pulse 2 clk after the last stop edge.
- Y direction and X clamp high:
  - Send 08,00,05. Expect ypos=379.
  - Starting from xpos=1020, send 08,20,00. Expect xpos=1023.
  - Starting from ypos=765, send 28,00,F6 (dy=-10). Expect ypos=767.
- Negative clamp: starting from xpos=100, send 18,80,00 (dx=-128). Expect xpos=0. Send 48,FF,00 (X overflow). Expect xpos unchanged and packet_valid still pulsed.
- Parity error: send byte1 with a wrong parity bit. Expect one rx_error pulse, no packet_valid, and state back to B0. The following valid packet 08,01,00 gives xpos+1.
- Resync and timeout:
  - Send 01 (bit3=0). Expect one rx_error and the byte dropped; the next valid packet then decodes correctly.
  - Separately, send 5 bits then idle for TIMEOUT+10 cycles. Expect one rx_error; the next full packet then decodes correctly.
- Async reset mid-frame: assert rst=0 during DATA of byte1. Outputs return to init immediately, and the first packet after release decodes correctly.
